// File: rtl/uart_cmder_mb_if.sv
// Signal bundle between the command decoder, the UART byte core and the
// register bus fabric. The decoder takes the master modport, the
// environment (UART core plus bus fabric) takes the slave modport.
//
// Handshakes:
//   - rx: uart_rx_rdy is a level meaning "a byte is waiting on uart_dout".
//     It stays high until the consumer pulses uart_rx_rdy_clr, so a byte
//     counts as taken only on a cycle where rx_rdy is high and clr is low.
//   - tx: uart_wr_en is a one-cycle pulse that transfers uart_din. It is
//     only issued while uart_tx_busy is low. busy rises the cycle after it.
//   - bus: bus_wr_en and bus_rd_en are one-cycle strobes and are never high
//     together. bus_rdata is valid only in the cycle bus_rd_rdy pulses.
interface uart_cmder_mb_if #(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 4
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    logic                  uart_wr_en;
    logic [7:0]            uart_din;
    logic                  uart_tx_busy;
    logic                  uart_rx_rdy;
    logic                  uart_rx_rdy_clr;
    logic [7:0]            uart_dout;
    logic                  bus_wr_en;
    logic [DATA_BYTES-1:0] bus_be;
    logic [AW-1:0]         bus_addr;
    logic [DW-1:0]         bus_wdata;
    logic                  bus_rd_en;
    logic [DW-1:0]         bus_rdata;
    logic                  bus_rd_rdy;

    modport master (
        output uart_wr_en, uart_din, uart_rx_rdy_clr,
        output bus_wr_en, bus_be, bus_addr, bus_wdata, bus_rd_en,
        input  uart_tx_busy, uart_rx_rdy, uart_dout,
        input  bus_rdata, bus_rd_rdy
    );

    modport slave (
        input  uart_wr_en, uart_din, uart_rx_rdy_clr,
        input  bus_wr_en, bus_be, bus_addr, bus_wdata, bus_rd_en,
        output uart_tx_busy, uart_rx_rdy, uart_dout,
        output bus_rdata, bus_rd_rdy
    );
endinterface

// File: rtl/uart_cmder_mb.sv
// Multi-byte UART command decoder. Frames are CMD, address bytes (MSB
// first) and, for writes, data bytes (MSB first). Writes become one bus
// write strobe with an optional ACK byte back; reads become one bus read
// strobe whose data (or an error byte on timeout) is sent back over UART.
module uart_cmder_mb #(
    parameter int         ADDR_BYTES = 2,
    parameter int         DATA_BYTES = 4,
    parameter int         RD_TIMEOUT = 255,
    parameter logic [7:0] ACK_BYTE   = 8'h55,
    parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
    input  logic                   clk,
    input  logic                   rstb,
    uart_cmder_mb_if.master        bus_if,
    output logic [2:0]             dbg_state_o
);
    localparam int         AW     = 8 * ADDR_BYTES;
    localparam int         DW     = 8 * DATA_BYTES;
    localparam logic [1:0] LAST_A = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] LAST_D = 2'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_WDATA    = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_TX       = 3'd4,
        S_TX_GUARD = 3'd5
    } state_t;

    state_t                state_q;
    logic                  rd_q;        // frame is a read
    logic                  ack_q;       // write acknowledge requested
    logic [1:0]            cnt_q;       // byte index within addr/data field
    logic [15:0]           tmo_q;       // read timeout countdown
    logic [2:0]            rem_q;       // tx bytes still to send
    logic [DW-1:0]         tx_sr_q;     // tx shift register, MSB byte goes first
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         wdata_q;
    logic [DATA_BYTES-1:0] be_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic                  uwr_q;
    logic [7:0]            udin_q;
    logic                  clr_q;

    logic                  got_byte;
    logic [AW-1:0]         addr_d;
    logic [DW-1:0]         wdata_d;

    // A byte is new only while the previous clear is not still in flight.
    assign got_byte = bus_if.uart_rx_rdy & ~clr_q;
    assign addr_d   = (addr_q << 8) | AW'(bus_if.uart_dout);
    assign wdata_d  = (wdata_q << 8) | DW'(bus_if.uart_dout);

    assign bus_if.uart_wr_en      = uwr_q;
    assign bus_if.uart_din        = udin_q;
    assign bus_if.uart_rx_rdy_clr = clr_q;
    assign bus_if.bus_wr_en       = wr_en_q;
    assign bus_if.bus_be          = be_q;
    assign bus_if.bus_addr        = addr_q;
    assign bus_if.bus_wdata       = wdata_q;
    assign bus_if.bus_rd_en       = rd_en_q;
    assign dbg_state_o            = state_q;

    // Frame parser, bus strobes and UART transmit sequencing.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            rem_q   <= '0;
            tx_sr_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            uwr_q   <= 1'b0;
            udin_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            // Every byte is cleared whatever the state; states that do not
            // parse simply drop it.
            clr_q   <= got_byte;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            uwr_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (got_byte && bus_if.uart_dout[7:2] == 6'd0) begin
                        rd_q    <= bus_if.uart_dout[0];
                        ack_q   <= bus_if.uart_dout[1];
                        cnt_q   <= '0;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (got_byte) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == LAST_A) begin
                            cnt_q <= '0;
                            if (rd_q) begin
                                rd_en_q <= 1'b1;
                                tmo_q   <= 16'(RD_TIMEOUT);
                                state_q <= S_RD_WAIT;
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (got_byte) begin
                        wdata_q <= wdata_d;
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == LAST_D) begin
                            cnt_q   <= '0;
                            wr_en_q <= 1'b1;
                            be_q    <= '1;
                            if (ack_q) begin
                                tx_sr_q <= DW'(ACK_BYTE) << (DW - 8);
                                rem_q   <= 3'd1;
                                state_q <= S_TX;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    tmo_q <= tmo_q - 16'd1;
                    // Data takes priority over a timeout expiring this cycle.
                    if (bus_if.bus_rd_rdy) begin
                        tx_sr_q <= bus_if.bus_rdata;
                        rem_q   <= 3'(DATA_BYTES);
                        state_q <= S_TX;
                    end else if (tmo_q == 16'd1) begin
                        tx_sr_q <= DW'(ERR_BYTE) << (DW - 8);
                        rem_q   <= 3'd1;
                        state_q <= S_TX;
                    end
                end
                S_TX: begin
                    if (!bus_if.uart_tx_busy) begin
                        uwr_q   <= 1'b1;
                        udin_q  <= tx_sr_q[DW-1 -: 8];
                        tx_sr_q <= tx_sr_q << 8;
                        rem_q   <= rem_q - 3'd1;
                        state_q <= S_TX_GUARD;
                    end
                end
                S_TX_GUARD: begin
                    // busy has not risen yet in this cycle, so it is not looked at.
                    state_q <= (rem_q != 3'd0) ? S_TX : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmder_mb.sv
// Bench for uart_cmder_mb: directed vector table, hand-written corner
// sequences and randomised frames checked against a frame-level model.
module tb_uart_cmder_mb;
    localparam int         AB  = 2;
    localparam int         DB  = 4;
    localparam int         RDT = 255;
    localparam logic [7:0] ACK = 8'h55;
    localparam logic [7:0] ERR = 8'hEE;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [63:0] frame;    // right-aligned, first byte is the most significant used
        int          nbytes;
        int          lat;      // bus read response latency, 0 = never answer
        logic [31:0] rdata;
        int          busy;     // tx busy length after each uart_wr_en
        int          exp_nwr;
        logic [47:0] exp_wr;   // {addr, wdata}
        int          exp_nrd;
        logic [15:0] exp_rd;
        int          exp_ntx;
        logic [31:0] exp_tx;   // right-aligned, first byte most significant
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    logic        rx_rdy    = 1'b0;
    logic [7:0]  rx_dout   = 8'h00;
    logic        tx_busy   = 1'b0;
    logic        rd_rdy    = 1'b0;
    logic [31:0] rd_data   = 32'h0;
    logic [2:0]  dbg_state;

    uart_cmder_mb_if #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) u_if ();

    assign u_if.uart_rx_rdy  = rx_rdy;
    assign u_if.uart_dout    = rx_dout;
    assign u_if.uart_tx_busy = tx_busy;
    assign u_if.bus_rd_rdy   = rd_rdy;
    assign u_if.bus_rdata    = rd_data;

    uart_cmder_mb #(
        .ADDR_BYTES(AB), .DATA_BYTES(DB), .RD_TIMEOUT(RDT),
        .ACK_BYTE(ACK), .ERR_BYTE(ERR)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .bus_if     (u_if),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [47:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_q[$];
    logic [47:0] act_wr_q[$];
    logic [15:0] act_rd_q[$];
    logic [7:0]  act_tx_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        exp_wr_q.delete(); exp_rd_q.delete(); exp_q.delete();
        act_wr_q.delete(); act_rd_q.delete(); act_tx_q.delete();
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, ".n_wr"}, 64'(act_wr_q.size()), 64'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size() && i < act_wr_q.size(); i++)
            chk({tag, ".wr"}, 64'(act_wr_q[i]), 64'(exp_wr_q[i]));
        chk({tag, ".n_rd"}, 64'(act_rd_q.size()), 64'(exp_rd_q.size()));
        for (int i = 0; i < exp_rd_q.size() && i < act_rd_q.size(); i++)
            chk({tag, ".rd_addr"}, 64'(act_rd_q[i]), 64'(exp_rd_q[i]));
        chk({tag, ".n_tx"}, 64'(act_tx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_tx_q.size(); i++)
            chk({tag, ".tx"}, 64'(act_tx_q[i]), 64'(exp_q[i]));
    endtask

    // ---------------- environment models and monitor ----------------
    int busy_len = 0;
    int busy_cnt = 0;
    int rd_lat   = 0;
    int rd_cnt   = 0;

    always @(negedge clk) begin
        if (u_if.uart_wr_en) begin
            chk("tx_while_busy", 64'(tx_busy), 64'(0));
            act_tx_q.push_back(u_if.uart_din);
        end
        if (u_if.bus_wr_en) begin
            chk("wr_rd_overlap", 64'(u_if.bus_rd_en), 64'(0));
            chk("bus_be", 64'(u_if.bus_be), 64'(4'hF));
            act_wr_q.push_back({u_if.bus_addr, u_if.bus_wdata});
        end
        if (u_if.bus_rd_en) act_rd_q.push_back(u_if.bus_addr);
        // UART tx core: busy from the cycle after a pulse for busy_len cycles.
        if (busy_cnt > 0) busy_cnt--;
        if (u_if.uart_wr_en && busy_len > 0) busy_cnt = busy_len;
        tx_busy = (busy_cnt > 0);
        // Bus fabric: answer a read strobe rd_lat cycles later.
        rd_rdy = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) rd_rdy = 1'b1;
        end
        if (u_if.bus_rd_en && rd_lat > 0) rd_cnt = rd_lat;
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_dout = b;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!u_if.uart_rx_rdy_clr && n < 20);
        chk("rx_consumed", 64'(u_if.uart_rx_rdy_clr), 64'(1));
        rx_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(dbg_state == 3'd0 && !tx_busy && rd_cnt == 0) && n < 2000);
        chk("back_to_idle", 64'(dbg_state), 64'(0));
        repeat (3) @(posedge clk);
    endtask

    task automatic play(input byte_q_t fb);
        foreach (fb[i]) send_byte(fb[i]);
        wait_idle();
    endtask

    // Frame-level reference: walks the byte stream the way the protocol
    // defines it and lists the bus operations and reply bytes it implies.
    task automatic model(input byte_q_t fb, input int lat, input logic [31:0] rdata);
        int i = 0;
        logic [7:0]  cmd;
        logic [15:0] a;
        logic [31:0] d;
        while (i < fb.size()) begin
            cmd = fb[i];
            i++;
            if (cmd[7:2] != 6'd0) continue;
            if (i + AB > fb.size()) break;
            a = 16'h0;
            for (int k = 0; k < AB; k++) begin a = (a << 8) | 16'(fb[i]); i++; end
            if (!cmd[0]) begin
                if (i + DB > fb.size()) break;
                d = 32'h0;
                for (int k = 0; k < DB; k++) begin d = (d << 8) | 32'(fb[i]); i++; end
                exp_wr_q.push_back({a, d});
                if (cmd[1]) exp_q.push_back(ACK);
            end else begin
                exp_rd_q.push_back(a);
                // The strobe cycle is the first of RDT cycles in which data is accepted.
                if (lat >= 1 && lat < RDT) begin
                    for (int k = 0; k < DB; k++) exp_q.push_back(8'(rdata >> (8 * (DB - 1 - k))));
                end else begin
                    exp_q.push_back(ERR);
                end
            end
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t    vecs[9];
    byte_q_t fb;
    logic [7:0] b8;
    int kind;

    initial begin
        vecs[0] = '{64'h0012_34DE_ADBE_EF, 7, 0, 32'h0, 0,
                    1, 48'h1234_DEAD_BEEF, 0, 16'h0, 0, 32'h0};
        vecs[1] = '{64'h0200_1000_0000_01, 7, 0, 32'h0, 2,
                    1, 48'h0010_0000_0001, 0, 16'h0, 1, 32'h55};
        vecs[2] = '{64'h0100_20, 3, 5, 32'hCAFE_F00D, 20,
                    0, 48'h0, 1, 16'h0020, 4, 32'hCAFE_F00D};
        vecs[3] = '{64'h0100_30, 3, 300, 32'h1234_5678, 0,
                    0, 48'h0, 1, 16'h0030, 1, 32'hEE};
        vecs[4] = '{64'h0700_ABCD_0102_0304, 8, 0, 32'h0, 0,
                    1, 48'hABCD_0102_0304, 0, 16'h0, 0, 32'h0};
        vecs[5] = '{64'h01BE_EF, 3, 254, 32'h1122_3344, 1,
                    0, 48'h0, 1, 16'hBEEF, 4, 32'h1122_3344};
        vecs[6] = '{64'h01BE_F0, 3, 255, 32'h1122_3344, 0,
                    0, 48'h0, 1, 16'hBEF0, 1, 32'hEE};
        vecs[7] = '{64'h0300_40, 3, 2, 32'hA5C3_5A3C, 0,
                    0, 48'h0, 1, 16'h0040, 4, 32'hA5C3_5A3C};
        vecs[8] = '{64'hFC01_0050, 4, 1, 32'h0102_0304, 3,
                    0, 48'h0, 1, 16'h0050, 4, 32'h0102_0304};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.bus_wr_en", 64'(u_if.bus_wr_en), 64'(0));
        chk("rst.bus_rd_en", 64'(u_if.bus_rd_en), 64'(0));
        chk("rst.uart_wr_en", 64'(u_if.uart_wr_en), 64'(0));
        chk("rst.bus_addr", 64'(u_if.bus_addr), 64'(0));
        chk("rst.bus_be", 64'(u_if.bus_be), 64'(0));
        chk("rst.state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(posedge clk);

        // Directed table.
        for (int v = 0; v < 9; v++) begin
            clear_logs();
            busy_len = vecs[v].busy;
            rd_lat   = vecs[v].lat;
            rd_data  = vecs[v].rdata;
            fb.delete();
            for (int i = 0; i < vecs[v].nbytes; i++)
                fb.push_back(vecs[v].frame[8 * (vecs[v].nbytes - 1 - i) +: 8]);
            if (vecs[v].exp_nwr > 0) exp_wr_q.push_back(vecs[v].exp_wr);
            if (vecs[v].exp_nrd > 0) exp_rd_q.push_back(vecs[v].exp_rd);
            for (int k = 0; k < vecs[v].exp_ntx; k++)
                exp_q.push_back(vecs[v].exp_tx[8 * (vecs[v].exp_ntx - 1 - k) +: 8]);
            play(fb);
            compare_logs($sformatf("vec%0d", v));
        end

        // Strobe latency: one cycle after the last byte is taken.
        clear_logs();
        busy_len = 0;
        rd_lat   = 3;
        rd_data  = 32'h0BAD_F00D;
        send_byte(8'h00); send_byte(8'h77); send_byte(8'h88);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04);
        chk("lat.bus_wr_en", 64'(u_if.bus_wr_en), 64'(1));
        chk("lat.bus_wdata", 64'(u_if.bus_wdata), 64'(32'h0102_0304));
        wait_idle();
        send_byte(8'h01); send_byte(8'h00);
        chk("lat.no_early_rd", 64'(u_if.bus_rd_en), 64'(0));
        send_byte(8'h60);
        chk("lat.bus_rd_en", 64'(u_if.bus_rd_en), 64'(1));
        wait_idle();
        exp_wr_q.push_back(48'h7788_0102_0304);
        exp_rd_q.push_back(16'h0060);
        for (int k = 0; k < DB; k++) exp_q.push_back(8'(32'h0BAD_F00D >> (8 * (DB - 1 - k))));
        compare_logs("lat");

        // Bytes arriving while the reply is being sent are dropped.
        clear_logs();
        busy_len = 20;
        rd_lat   = 5;
        rd_data  = 32'hCAFE_F00D;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h70);
        repeat (15) @(posedge clk);
        send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
        wait_idle();
        fb = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        play(fb);
        exp_rd_q.push_back(16'h0070);
        exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        exp_wr_q.push_back(48'h1122_3344_5566);
        compare_logs("rx_in_tx");

        // Reset in the middle of a frame.
        clear_logs();
        busy_len = 0;
        send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        @(negedge clk);
        rstb = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst.bus_addr", 64'(u_if.bus_addr), 64'(0));
        chk("mid_rst.bus_wdata", 64'(u_if.bus_wdata), 64'(0));
        chk("mid_rst.bus_be", 64'(u_if.bus_be), 64'(0));
        chk("mid_rst.uart_din", 64'(u_if.uart_din), 64'(0));
        chk("mid_rst.state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        rstb = 1'b1;
        fb = '{8'h00, 8'h56, 8'h78, 8'h11, 8'h22, 8'h33, 8'h44};
        play(fb);
        exp_wr_q.push_back(48'h5678_1122_3344);
        compare_logs("mid_rst");

        // Randomised frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            clear_logs();
            fb.delete();
            busy_len = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0:       rd_lat = RDT;
                1:       rd_lat = RDT - 1;
                default: rd_lat = $urandom_range(1, 12);
            endcase
            rd_data = $urandom;
            if ($urandom_range(0, 3) == 0) fb.push_back(8'($urandom_range(4, 255)));
            kind = $urandom_range(0, 2);
            if (kind == 0)      b8 = 8'h00;
            else if (kind == 1) b8 = 8'h02;
            else                b8 = 8'h01 | 8'($urandom_range(0, 1) << 1);
            fb.push_back(b8);
            for (int k = 0; k < AB; k++) fb.push_back(8'($urandom));
            if (kind != 2) for (int k = 0; k < DB; k++) fb.push_back(8'($urandom));
            model(fb, rd_lat, rd_data);
            play(fb);
            compare_logs($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_cmder_mb.md
Name: uart_cmder_mb

Overview:
Parametrised successor to the single-byte UART command decoder. Parses multi-byte UART frames of command, N address bytes and M data bytes into full-width register-bus writes and reads. Read data is returned as M bytes over UART. Adds an optional write acknowledge and a read timeout with error byte. Sits between the UART byte core (rx/tx) and the register bus fabric.

Parameters:
ADDR_BYTES, 2, number of address bytes per frame (1..4); bus_addr width AW = 8*ADDR_BYTES
DATA_BYTES, 4, number of data bytes per frame (1..4); bus data width DW = 8*DATA_BYTES
RD_TIMEOUT, 255, cycles to wait for bus_rd_rdy after bus_rd_en before aborting (1..65535)
ACK_BYTE, 8'h55, byte sent after an acknowledged write
ERR_BYTE, 8'hEE, byte sent on read timeout

Ports:
clk  input  1  system clock
rstb  input  1  synchronous active-low reset
uart_wr_en  output  1  one-cycle pulse: transmit uart_din
uart_din  output  8  tx byte
uart_tx_busy  input  1  tx core busy; rises the cycle after uart_wr_en
uart_rx_rdy  input  1  rx byte available (level until cleared)
uart_rx_rdy_clr  output  1  registered clear of uart_rx_rdy
uart_dout  input  8  rx byte
bus_wr_en  output  1  one-cycle write strobe
bus_be  output  DATA_BYTES  byte enables (all ones)
bus_addr  output  AW  bus address
bus_wdata  output  DW  write data
bus_rd_en  output  1  one-cycle read strobe
bus_rdata  input  DW  read data, valid with bus_rd_rdy
bus_rd_rdy  input  1  read data valid pulse

Behaviour:
- Single clock clk; reset synchronous on rstb low at a clk edge. All outputs 0 in reset, state IDLE, counters 0.
- got_byte = uart_rx_rdy & ~uart_rx_rdy_clr. uart_rx_rdy_clr <= got_byte every cycle in every state, so each byte is consumed exactly once.
- Frame: CMD, then ADDR_BYTES address bytes MSB first, then for write DATA_BYTES data bytes MSB first. CMD bit0: 0 = write, 1 = read. CMD bit1: write-ack request (ignored for read). CMD[7:2] != 0 is invalid: byte dropped, stay IDLE.
- States: IDLE, ADDR, WDATA, RD_WAIT, TX, TX_GUARD.
- IDLE: on a valid got_byte, latch cmd, clear byte counter, go to ADDR.
- ADDR: each got_byte shifts into bus_addr from the LSB side (addr <= {addr[AW-9:0], byte}). On the ADDR_BYTES-th byte:
  - write: go to WDATA.
  - read: pulse bus_rd_en the next cycle, load timeout counter = RD_TIMEOUT, go to RD_WAIT.
- WDATA: bytes shift into bus_wdata the same way. On the DATA_BYTES-th byte, in the following cycle: bus_wr_en = 1 for one cycle, bus_be = all ones, bus_addr/bus_wdata stable.
  - If ack requested: load tx shift register with ACK_BYTE, 1 byte remaining, go to TX.
  - Else: go to IDLE.
- RD_WAIT: counter decrements each cycle.
  - bus_rd_rdy: capture bus_rdata, DATA_BYTES remaining, go to TX.
  - Counter reaches 0 without rdy: load ERR_BYTE, 1 remaining, go to TX.
  - bus_rd_rdy on the same cycle the counter hits 0: data wins.
  - bus_rd_rdy outside RD_WAIT is ignored.
- TX: when uart_tx_busy == 0, pulse uart_wr_en with uart_din = current MSB byte, shift left 8, decrement remaining, go to TX_GUARD.
- TX_GUARD: one cycle, uart_tx_busy ignored. Then TX if remaining > 0, else IDLE.
- Rx bytes received in RD_WAIT/TX/TX_GUARD are cleared and discarded.
- bus_addr/bus_wdata hold their last values until overwritten. bus_wr_en and bus_rd_en are never high simultaneously.
- Reset mid-frame or mid-transmit: immediate return to IDLE, partial frame lost, no strobe issued.
- Latency: last write byte got_byte -> bus_wr_en 1 cycle later; last addr byte -> bus_rd_en 1 cycle later; bus_rd_rdy -> first uart_wr_en after 1 cycle minimum.

Test Plan:
- Write: rx 00,12,34,DE,AD,BE,EF -> one bus_wr_en, bus_addr = 16'h1234, bus_wdata = 32'hDEADBEEF, bus_be = 4'hF, no uart_wr_en.
- Acked write: rx 02,00,10,00,00,00,01 -> bus_wr_en, then one uart_wr_en with uart_din = 8'h55.
- Read: rx 01,00,20; bus_rd_rdy 5 cycles after bus_rd_en with rdata 32'hCAFEF00D -> uart_din sequence CA,FE,F0,0D. With tx_busy held high 20 cycles after each pulse, no pulse occurs while busy.
- Read timeout: rx 01,00,30 and no bus_rd_rdy -> after 255 cycles a single uart_din = 8'hEE. A late bus_rd_rdy is ignored and the block is back in IDLE.
- Invalid cmd and extra rx: rx 07 -> no bus activity, the next 00 frame works. Bytes received during TX are cleared and not parsed.
- Reset mid-frame: rstb low after 00,12,34 -> all outputs 0. The following full write frame decodes correctly.
